// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle datapath control FSM with memory wait handshake
module multicycle_ctrl (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_field_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       branch_ne_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic       ext_zero_o,
    output logic [2:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_EXEC_I   = 4'd10,
        S_I_WB     = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

    always_comb begin
        state_d         = S_FETCH;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        branch_ne_o     = 1'b0;
        i_or_d_o        = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'b00;
        ext_zero_o      = 1'b0;
        alu_op_o        = 3'b000;
        pc_source_o     = 2'b00;
        illegal_o       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                state_d     = mem_ready_i ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b_o = 2'b11;
                case (op_field_i)
                    OP_RTYPE:              state_d = S_EXEC_R;
                    OP_LW, OP_SW:          state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:        state_d = S_BRANCH;
                    OP_J:                  state_d = S_JUMP;
                    OP_ADDI, OP_ORI, OP_LUI: state_d = S_EXEC_I;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                state_d     = (op_field_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
                state_d    = mem_ready_i ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
                state_d     = mem_ready_i ? S_FETCH : S_MEM_WR;
            end
            S_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'b010;
                state_d     = S_R_WB;
            end
            S_R_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = 3'b001;
                pc_write_cond_o = 1'b1;
                pc_source_o     = 2'b01;
                branch_ne_o     = (op_field_i == OP_BNE);
            end
            S_JUMP: begin
                pc_write_o  = 1'b1;
                pc_source_o = 2'b10;
            end
            S_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                state_d     = S_I_WB;
                // addi keeps the add/sign-extend defaults
                if (op_field_i == OP_ORI) begin
                    alu_op_o   = 3'b011;
                    ext_zero_o = 1'b1;
                end else if (op_field_i == OP_LUI) begin
                    alu_op_o   = 3'b100;
                    ext_zero_o = 1'b1;
                end
            end
            S_I_WB: begin
                reg_write_o = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        // Strobes are held off for the whole reset cycle, whatever state we are leaving
        if (rst_i) begin
            pc_write_o      = 1'b0;
            pc_write_cond_o = 1'b0;
            ir_write_o      = 1'b0;
            reg_write_o     = 1'b0;
            mem_read_o      = 1'b0;
            mem_write_o     = 1'b0;
            illegal_o       = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'd0;
    logic       rdy = 1'b0;
    logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, ext_zero, illegal;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;

    multicycle_ctrl dut (
        .clk_i(clk), .rst_i(rst), .op_field_i(op), .mem_ready_i(rdy),
        .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .branch_ne_o(branch_ne),
        .i_or_d_o(i_or_d), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .ir_write_o(ir_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
        .reg_write_o(reg_write), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
        .ext_zero_o(ext_zero), .alu_op_o(alu_op), .pc_source_o(pc_source),
        .illegal_o(illegal), .state_o(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [3:0]  st;
        logic [19:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;
    bit   done = 1'b0;

    wire [19:0] act_vec = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
                           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                           ext_zero, alu_op, pc_source, illegal};

    function automatic logic [19:0] expect_vec(logic [3:0] st, logic [5:0] opc, logic r, logic rs);
        logic pw, pwc, bn, iod, mr, mw, irw, rd, m2r, rw, asa, ez, ill;
        logic [1:0] asb, ps;
        logic [2:0] aop;
        {pw, pwc, bn, iod, mr, mw, irw, rd, m2r, rw, asa, ez, ill} = '0;
        asb = 2'b00; ps = 2'b00; aop = 3'b000;
        case (st)
            4'd0:  begin mr = 1; asb = 2'b01; pw = r; irw = r; end
            4'd1:  begin
                asb = 2'b11;
                ill = !(opc inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0d, 6'h0f});
            end
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mr = 1; iod = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; iod = 1; end
            4'd6:  begin asa = 1; aop = 3'b010; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin asa = 1; aop = 3'b001; pwc = 1; ps = 2'b01; bn = (opc == 6'h05); end
            4'd9:  begin pw = 1; ps = 2'b10; end
            4'd10: begin
                asa = 1; asb = 2'b10;
                if (opc == 6'h0d) begin aop = 3'b011; ez = 1; end
                if (opc == 6'h0f) begin aop = 3'b100; ez = 1; end
            end
            4'd11: rw = 1;
            default: ;
        endcase
        if (rs) {pw, pwc, irw, rw, mr, mw, ill} = '0;
        return {pw, pwc, bn, iod, mr, mw, irw, rd, m2r, rw, asa, asb, ez, aop, ps, ill};
    endfunction

    // Apply one cycle of inputs and record what that cycle must look like
    task automatic cyc(input logic [5:0] o, input logic r, input logic rs, input logic [3:0] st);
        exp_t e;
        @(posedge clk);
        #1;
        op = o; rdy = r; rst = rs;
        cyc_no++;
        e.cyc = cyc_no;
        e.st  = st;
        e.vec = expect_vec(st, o, r, rs);
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (state !== e.st) begin
                errors++;
                $display("FAIL state cycle %0d actual %0d required %0d", e.cyc, state, e.st);
            end
            checks++;
            if (act_vec !== e.vec) begin
                errors++;
                $display("FAIL outputs cycle %0d actual %05h required %05h", e.cyc, act_vec, e.vec);
            end
            checks++;
            if (mem_read && mem_write) begin
                errors++;
                $display("FAIL mem_exclusive cycle %0d actual 11 required not both", e.cyc);
            end
        end
    end

    initial begin
        cyc(6'h00, 1, 1, 0);
        cyc(6'h00, 1, 1, 0);
        // R-type: 0,1,6,7 with mem_ready tied high (ignored outside memory states)
        cyc(6'h00, 1, 0, 0); cyc(6'h00, 1, 0, 1); cyc(6'h00, 1, 0, 6); cyc(6'h00, 1, 0, 7);
        // lw with two wait cycles in MEM_RD
        cyc(6'h23, 1, 0, 0); cyc(6'h23, 1, 0, 1); cyc(6'h23, 1, 0, 2);
        cyc(6'h23, 0, 0, 3); cyc(6'h23, 0, 0, 3); cyc(6'h23, 1, 0, 3); cyc(6'h23, 0, 0, 4);
        // sw with one fetch wait, no write wait
        cyc(6'h2b, 0, 0, 0); cyc(6'h2b, 1, 0, 0); cyc(6'h2b, 0, 0, 1); cyc(6'h2b, 0, 0, 2);
        cyc(6'h2b, 1, 0, 5);
        // bne, beq, j
        cyc(6'h05, 1, 0, 0); cyc(6'h05, 1, 0, 1); cyc(6'h05, 1, 0, 8);
        cyc(6'h04, 1, 0, 0); cyc(6'h04, 0, 0, 1); cyc(6'h04, 1, 0, 8);
        cyc(6'h02, 1, 0, 0); cyc(6'h02, 1, 0, 1); cyc(6'h02, 1, 0, 9);
        // addi, ori, lui
        cyc(6'h08, 1, 0, 0); cyc(6'h08, 1, 0, 1); cyc(6'h08, 1, 0, 10); cyc(6'h08, 1, 0, 11);
        cyc(6'h0d, 1, 0, 0); cyc(6'h0d, 1, 0, 1); cyc(6'h0d, 1, 0, 10); cyc(6'h0d, 1, 0, 11);
        cyc(6'h0f, 1, 0, 0); cyc(6'h0f, 1, 0, 1); cyc(6'h0f, 1, 0, 10); cyc(6'h0f, 1, 0, 11);
        // illegal opcodes: one-cycle pulse in DECODE, straight back to FETCH
        cyc(6'h3f, 1, 0, 0); cyc(6'h3f, 1, 0, 1);
        cyc(6'h03, 1, 0, 0); cyc(6'h03, 1, 0, 1);
        // sw stalled in MEM_WR, then reset mid-wait
        cyc(6'h2b, 1, 0, 0); cyc(6'h2b, 1, 0, 1); cyc(6'h2b, 1, 0, 2);
        cyc(6'h2b, 0, 0, 5); cyc(6'h2b, 0, 0, 5); cyc(6'h2b, 0, 1, 5);
        cyc(6'h2b, 0, 0, 0); cyc(6'h2b, 0, 0, 0);
        done = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain actual %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 No parameters; all encodings below are fixed.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 op_field_i  input  6  instruction opcode from the instruction register.
REQ-005 mem_ready_i  input  1  memory completes the current access this cycle.
REQ-006 pc_write_o  output  1  unconditional PC load.
REQ-007 pc_write_cond_o  output  1  PC load when the branch condition holds.
REQ-008 branch_ne_o  output  1  branch condition select: 0 = ALU zero (beq), 1 = not zero (bne).
REQ-009 i_or_d_o  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 mem_read_o, mem_write_o  output  1 each  memory strobes.
REQ-011 ir_write_o  output  1  instruction register load.
REQ-012 reg_dst_o  output  1  write register select: 0 = rt, 1 = rd.
REQ-013 mem_to_reg_o  output  1  write data select: 0 = ALUOut, 1 = MDR.
REQ-014 reg_write_o  output  1  register file write enable.
REQ-015 alu_src_a_o  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-016 alu_src_b_o  output  2  ALU B select: 00 = B, 01 = 4, 10 = extended immediate, 11 = sign-extended immediate << 2.
REQ-017 ext_zero_o  output  1  immediate extension: 0 = sign, 1 = zero.
REQ-018 alu_op_o  output  3  000 add, 001 sub, 010 funct-decoded (R-type, including sra/srav), 011 or, 100 lui.
REQ-019 pc_source_o  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-020 illegal_o  output  1  one-cycle pulse on an unsupported opcode.
REQ-021 state_o  output  4  current state, for debug.

Function
REQ-022 State encoding:
- FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5
- EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, EXEC_I=10, I_WB=11
- codes 12-15 are unreachable and return to FETCH on the next edge.
REQ-023 Every output not listed for a state SHALL be 0.
REQ-024 FETCH:
- mem_read_o=1, i_or_d_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=000, pc_source_o=00.
- While mem_ready_i=0: ir_write_o=0, pc_write_o=0, and the FSM stays in FETCH.
- When mem_ready_i=1: ir_write_o=1 and pc_write_o=1 in that same cycle, then DECODE.
REQ-025 DECODE: alu_src_a_o=0, alu_src_b_o=11, alu_op_o=000 (branch target into ALUOut). Next state by opcode:
- 000000 -> EXEC_R
- 100011, 101011 -> MEM_ADDR
- 000100, 000101 -> BRANCH
- 000010 -> JUMP
- 001000, 001101, 001111 -> EXEC_I
- any other opcode -> FETCH, with illegal_o=1 in the DECODE cycle.
REQ-026 MEM_ADDR: alu_src_a_o=1, alu_src_b_o=10, alu_op_o=000; next state MEM_RD for 100011, MEM_WR for 101011.
REQ-027 MEM_RD: mem_read_o=1, i_or_d_o=1; hold until mem_ready_i=1, then MEM_WB.
REQ-028 MEM_WB: reg_write_o=1, mem_to_reg_o=1, reg_dst_o=0; next FETCH.
REQ-029 MEM_WR: mem_write_o=1, i_or_d_o=1; hold until mem_ready_i=1, then FETCH.
REQ-030 EXEC_R: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=010; next R_WB.
REQ-031 R_WB: reg_write_o=1, reg_dst_o=1, mem_to_reg_o=0; next FETCH.
REQ-032 BRANCH: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=001, pc_write_cond_o=1, pc_source_o=01; branch_ne_o = (op_field_i==000101); next FETCH.
REQ-033 JUMP: pc_write_o=1, pc_source_o=10; next FETCH.
REQ-034 EXEC_I: alu_src_a_o=1, alu_src_b_o=10, and by opcode:
- 001000: alu_op_o=000, ext_zero_o=0
- 001101: alu_op_o=011, ext_zero_o=1
- 001111: alu_op_o=100, ext_zero_o=1
- next state I_WB.
REQ-035 I_WB: reg_write_o=1, reg_dst_o=0, mem_to_reg_o=0; next FETCH.
REQ-036 Instruction latencies with zero memory wait:
- R-type, addi, ori, lui: 4 cycles
- lw: 5 cycles
- sw: 4 cycles
- beq, bne, j: 3 cycles
- each cycle of mem_ready_i=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
REQ-037 mem_read_o and mem_write_o SHALL never both be 1 in the same cycle.
REQ-038 A mem_ready_i pulse in a state with no memory access is ignored.

Reset
REQ-039 When rst_i=1 at a rising edge, the state becomes FETCH regardless of the current state, including mid-wait in MEM_RD or MEM_WR.
REQ-040 While rst_i=1, all strobes SHALL be forced to 0: pc_write_o, pc_write_cond_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o, illegal_o.
REQ-041 After rst_i deasserts, FETCH begins on the next cycle with state_o=0.

Verification
REQ-042 Reset, then opcode 000000 with mem_ready_i tied to 1 -> state_o sequence 0,1,6,7,0; reg_write_o=1 only in state 7, with reg_dst_o=1.
REQ-043 lw (100011) with mem_ready_i=0 for 2 cycles in MEM_RD -> states 0,1,2,3,3,3,4,0; mem_to_reg_o=1 and reg_write_o=1 in state 4.
REQ-044 bne (000101) -> states 0,1,8,0; in state 8, pc_write_cond_o=1, branch_ne_o=1, alu_op_o=001. Repeat with beq -> branch_ne_o=0.
REQ-045 ori (001101) and lui (001111) -> in EXEC_I, ext_zero_o=1 with alu_op_o=011 and 100 respectively; reg_write_o=1 in I_WB.
REQ-046 Opcode 111111 -> illegal_o=1 for exactly one cycle in DECODE, then FETCH, with no reg_write_o, mem_write_o or pc_write_o pulses.
REQ-047 sw stalled in MEM_WR with mem_ready_i=0, then rst_i=1 for one edge -> mem_write_o=0 in the reset cycle and state_o=0 on the next cycle.
